sap1_mem_arbiter: RTL and testbench

Two-port arbiter that shares the SAP-1 16x8 program/data memory between the CPU fetch/operand path and an external program loader. It serialises accesses through a small FSM, provides request/grant and read-valid handshakes to both sides, and stalls the CPU while the loader owns the memory. It sits between the control-unit/MAR path and the single-port synchronous memory, replacing direct MAR-to-memory wiring.

---
 rtl/sap1_pkg.sv | 24 ++
 rtl/sap1_mem_arbiter.sv | 137 +++++++++++++
 tb/tb_sap1_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sap1_pkg.sv
// rtl/sap1_pkg.sv - shared widths, arbiter state encoding and arbitration mode constants
package sap1_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    localparam logic ARB_ROUND_ROBIN = 1'b0;
    localparam logic ARB_LD_FIXED    = 1'b1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CPU_ACC = 3'd1,
        CPU_RSP = 3'd2,
        LD_WR   = 3'd3,
        LD_RD   = 3'd4,
        LD_RSP  = 3'd5
    } arb_state_t;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_LD  = 1'b1
    } grant_t;

endpackage

// File: rtl/sap1_mem_arbiter.sv
// rtl/sap1_mem_arbiter.sv - CPU/loader arbiter for the SAP-1 16x8 memory; SAP1_ARB_RDBACK_EN enables loader reads
module sap1_mem_arbiter
    import sap1_pkg::*;
#(
    parameter logic ARB_MODE = ARB_ROUND_ROBIN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_mode,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_valid,
    output logic              cpu_stall,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t state, state_next;
    grant_t     last_grant, last_grant_next;

    logic cpu_elig;
    logic ld_elig;
    logic pick_ld;

`ifdef SAP1_ARB_RDBACK_EN
    assign ld_elig = ld_req;
`else
    assign ld_elig = ld_req & ld_we;
`endif
    assign cpu_elig = cpu_req & ~prog_mode;

    // Loader wins when alone, in fixed-priority mode, or when the CPU had the last turn.
    assign pick_ld = ld_elig & (~cpu_elig | (ARB_MODE == ARB_LD_FIXED) | (last_grant == GNT_CPU));

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        mem_en          = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        ld_gnt          = 1'b0;
        case (state)
            IDLE: begin
                if (pick_ld) begin
                    last_grant_next = GNT_LD;
`ifdef SAP1_ARB_RDBACK_EN
                    state_next = ld_we ? LD_WR : LD_RD;
`else
                    state_next = LD_WR;
`endif
                end else if (cpu_elig) begin
                    last_grant_next = GNT_CPU;
                    state_next      = CPU_ACC;
                end
            end
            CPU_ACC: begin
                mem_en     = 1'b1;
                mem_addr   = cpu_addr;
                state_next = CPU_RSP;
            end
            CPU_RSP: begin
                state_next = IDLE;
            end
            LD_WR: begin
                mem_en     = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = ld_addr;
                mem_wdata  = ld_wdata;
                ld_gnt     = 1'b1;
                state_next = IDLE;
            end
`ifdef SAP1_ARB_RDBACK_EN
            LD_RD: begin
                mem_en     = 1'b1;
                mem_addr   = ld_addr;
                ld_gnt     = 1'b1;
                state_next = LD_RSP;
            end
            LD_RSP: begin
                state_next = IDLE;
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= GNT_CPU;
            cpu_rdata  <= '0;
            cpu_valid  <= 1'b0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            cpu_valid  <= (state == CPU_RSP);
            if (state == CPU_RSP) begin
                cpu_rdata <= mem_rdata;
            end
        end
    end

`ifdef SAP1_ARB_RDBACK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_rdata  <= '0;
            ld_rvalid <= 1'b0;
        end else begin
            ld_rvalid <= (state == LD_RSP);
            if (state == LD_RSP) begin
                ld_rdata <= mem_rdata;
            end
        end
    end
`else
    assign ld_rdata  = '0;
    assign ld_rvalid = 1'b0;
`endif

    // The completion pulse ends the stall in that same cycle even if cpu_req is still high.
    assign cpu_stall = prog_mode | (cpu_req & ~cpu_valid);

endmodule

// File: tb/tb_sap1_mem_arbiter.sv
// tb/tb_sap1_mem_arbiter.sv - directed bench: round-robin and loader-priority arbiters side by side
module tb_sap1_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       prog_mode;
    logic       cpu_req;
    logic [3:0] cpu_addr;
    logic       ld_req;
    logic       ld_we;
    logic [3:0] ld_addr;
    logic [7:0] ld_wdata;

    logic [7:0] cpu_rdata0, cpu_rdata1, ld_rdata0, ld_rdata1;
    logic       cpu_valid0, cpu_valid1, cpu_stall0, cpu_stall1;
    logic       ld_gnt0, ld_gnt1, ld_rvalid0, ld_rvalid1;
    logic       mem_en0, mem_en1, mem_we0, mem_we1;
    logic [3:0] mem_addr0, mem_addr1;
    logic [7:0] mem_wdata0, mem_wdata1, mem_rdata0, mem_rdata1;

    logic [7:0] mem0 [16];
    logic [7:0] mem1 [16];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sap1_mem_arbiter #(.ARB_MODE(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .prog_mode(prog_mode),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_rdata(cpu_rdata0),
        .cpu_valid(cpu_valid0), .cpu_stall(cpu_stall0),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt0), .ld_rdata(ld_rdata0), .ld_rvalid(ld_rvalid0),
        .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0),
        .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
    );

    sap1_mem_arbiter #(.ARB_MODE(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .prog_mode(prog_mode),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_rdata(cpu_rdata1),
        .cpu_valid(cpu_valid1), .cpu_stall(cpu_stall1),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt1), .ld_rdata(ld_rdata1), .ld_rvalid(ld_rvalid1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
    );

    // Single-port synchronous 16x8 memories, one per arbiter
    initial begin
        for (int i = 0; i < 16; i++) begin
            mem0[i] = 8'h00;
            mem1[i] = 8'h00;
        end
        mem_rdata0 = 8'h00;
        mem_rdata1 = 8'h00;
    end

    always @(posedge clk) begin
        if (mem_en0) begin
            if (mem_we0) mem0[mem_addr0] <= mem_wdata0;
            else         mem_rdata0 <= mem0[mem_addr0];
        end
        if (mem_en1) begin
            if (mem_we1) mem1[mem_addr1] <= mem_wdata1;
            else         mem_rdata1 <= mem1[mem_addr1];
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [35:0] outs;
        rst_n = 1'b0; prog_mode = 1'b0; cpu_req = 1'b0; cpu_addr = 4'h0;
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = 4'h0; ld_wdata = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        outs = {cpu_rdata0, cpu_valid0, cpu_stall0, ld_gnt0, ld_rdata0, ld_rvalid0,
                mem_en0, mem_we0, mem_addr0, mem_wdata0};
        n_tests++;
        if (outs !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_idle_outputs: got %h want 0", outs);
        end
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 4'h2; ld_wdata = 8'h55;
        @(negedge clk);
        n_tests++;
        if (ld_gnt0 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_ld_gnt: got %b want 1", ld_gnt0);
        end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({ld_gnt0, mem_en0, mem_we0, mem_addr0, mem_wdata0} !== 15'h0) begin
            n_fail++;
            $display("FAIL reset_mid_write: gnt=%b en=%b we=%b addr=%h wdata=%h want all 0",
                     ld_gnt0, mem_en0, mem_we0, mem_addr0, mem_wdata0);
        end
        ld_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({ld_gnt0, mem_en0, cpu_valid0, ld_rvalid0} !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_release: gnt=%b en=%b cv=%b lrv=%b want 0",
                     ld_gnt0, mem_en0, cpu_valid0, ld_rvalid0);
        end
    endtask

    task automatic test_cpu_read();
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 4'h3; ld_wdata = 8'h1D;
        @(negedge clk);
        n_tests++;
        if ({ld_gnt0, mem_en0, mem_we0, mem_addr0, mem_wdata0} !== {3'b111, 4'h3, 8'h1D}) begin
            n_fail++;
            $display("FAIL ld_write_strobe: gnt=%b en=%b we=%b addr=%h wdata=%h want 1 1 1 3 1d",
                     ld_gnt0, mem_en0, mem_we0, mem_addr0, mem_wdata0);
        end
        ld_req = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 4'h3;
        #1;
        n_tests++;
        if (cpu_stall0 !== 1'b1) begin
            n_fail++;
            $display("FAIL cpu_stall_pending: got %b want 1", cpu_stall0);
        end
        @(negedge clk);
        n_tests++;
        if ({mem_en0, mem_we0, mem_addr0} !== {2'b10, 4'h3}) begin
            n_fail++;
            $display("FAIL cpu_mem_strobe: en=%b we=%b addr=%h want 1 0 3", mem_en0, mem_we0, mem_addr0);
        end
        @(negedge clk);
        n_tests++;
        if (cpu_valid0 !== 1'b0) begin
            n_fail++;
            $display("FAIL cpu_valid_early: got %b want 0", cpu_valid0);
        end
        @(negedge clk);
        n_tests++;
        if ({cpu_valid0, cpu_rdata0, cpu_stall0} !== {1'b1, 8'h1D, 1'b0}) begin
            n_fail++;
            $display("FAIL cpu_read_n3: valid=%b rdata=%h stall=%b want 1 1d 0",
                     cpu_valid0, cpu_rdata0, cpu_stall0);
        end
        cpu_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({cpu_valid0, cpu_rdata0, mem_en0} !== {1'b0, 8'h1D, 1'b0}) begin
            n_fail++;
            $display("FAIL cpu_read_after: valid=%b rdata=%h en=%b want 0 1d 0",
                     cpu_valid0, cpu_rdata0, mem_en0);
        end
    endtask

    task automatic test_arbitration();
        logic [3:0] seq0;
        int         n_gnt0;
        int         n_gnt1;
        int         stall1_low;
        int         valid1_seen;
        logic [7:0] first_rdata;
        logic       got_rdata;
        do_reset();
        seq0 = 4'h0; n_gnt0 = 0; n_gnt1 = 0; stall1_low = 0; valid1_seen = 0;
        first_rdata = 8'h00; got_rdata = 1'b0;
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 4'h7; ld_wdata = 8'hA5;
        cpu_req = 1'b1; cpu_addr = 4'h7;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (mem_en0) begin
                if (n_gnt0 < 4) seq0[3 - n_gnt0] = mem_we0;
                n_gnt0++;
            end
            if (cpu_valid0 && !got_rdata) begin
                first_rdata = cpu_rdata0;
                got_rdata   = 1'b1;
            end
            if (ld_gnt1) n_gnt1++;
            if (cpu_stall1 !== 1'b1) stall1_low++;
            if (cpu_valid1 !== 1'b0) valid1_seen++;
        end
        ld_req = 1'b0; cpu_req = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++;
        if (seq0 !== 4'b1010 || n_gnt0 !== 5) begin
            n_fail++;
            $display("FAIL rr_order: seq(1=L)=%b count=%0d want 1010 count 5", seq0, n_gnt0);
        end
        n_tests++;
        if (got_rdata !== 1'b1 || first_rdata !== 8'hA5) begin
            n_fail++;
            $display("FAIL rr_cpu_data: seen=%b rdata=%h want 1 a5", got_rdata, first_rdata);
        end
        n_tests++;
        if (n_gnt1 !== 6 || valid1_seen !== 0 || stall1_low !== 0) begin
            n_fail++;
            $display("FAIL fixed_starve: ld_gnt=%0d cpu_valid=%0d stall_low=%0d want 6 0 0",
                     n_gnt1, valid1_seen, stall1_low);
        end
    endtask

    task automatic test_prog_mode();
        int n_gnt;
        int valid_seen;
        int stall_low;
        int wait_cyc;
        n_gnt = 0; valid_seen = 0; stall_low = 0; wait_cyc = 0;
        @(negedge clk);
        prog_mode = 1'b1; cpu_req = 1'b1; cpu_addr = 4'h0;
        for (int i = 0; i < 16; i++) begin
            ld_req = 1'b1; ld_we = 1'b1; ld_addr = 4'(i); ld_wdata = 8'(i);
            @(negedge clk);
            if (ld_gnt0 && mem_addr0 == 4'(i) && mem_wdata0 == 8'(i)) n_gnt++;
            if (cpu_valid0) valid_seen++;
            if (!cpu_stall0) stall_low++;
            ld_req = 1'b0;
            @(negedge clk);
            if (cpu_valid0) valid_seen++;
            if (!cpu_stall0) stall_low++;
        end
        n_tests++;
        if (n_gnt !== 16 || valid_seen !== 0 || stall_low !== 0) begin
            n_fail++;
            $display("FAIL prog_mode_block: writes=%0d cpu_valid=%0d stall_low=%0d want 16 0 0",
                     n_gnt, valid_seen, stall_low);
        end
        prog_mode = 1'b0;
        while (!cpu_valid0 && wait_cyc < 8) begin
            @(negedge clk);
            wait_cyc++;
        end
        n_tests++;
        if (cpu_valid0 !== 1'b1 || cpu_rdata0 !== 8'h00 || wait_cyc !== 3) begin
            n_fail++;
            $display("FAIL prog_release_read: valid=%b rdata=%h cycles=%0d want 1 00 3",
                     cpu_valid0, cpu_rdata0, wait_cyc);
        end
        cpu_req = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_readback();
`ifdef SAP1_ARB_RDBACK_EN
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 4'hF; ld_wdata = 8'h3C;
        @(negedge clk);
        ld_req = 1'b0;
        @(negedge clk);
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 4'hF;
        @(negedge clk);
        n_tests++;
        if ({ld_gnt0, mem_en0, mem_we0, mem_addr0} !== {3'b110, 4'hF}) begin
            n_fail++;
            $display("FAIL ld_read_strobe: gnt=%b en=%b we=%b addr=%h want 1 1 0 f",
                     ld_gnt0, mem_en0, mem_we0, mem_addr0);
        end
        ld_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if (ld_rvalid0 !== 1'b0) begin
            n_fail++;
            $display("FAIL ld_rvalid_early: got %b want 0", ld_rvalid0);
        end
        @(negedge clk);
        n_tests++;
        if (ld_rvalid0 !== 1'b1 || ld_rdata0 !== 8'h3C) begin
            n_fail++;
            $display("FAIL ld_readback: rvalid=%b rdata=%h want 1 3c", ld_rvalid0, ld_rdata0);
        end
        @(negedge clk);
`else
        int n_gnt;
        int n_en;
        int n_rv;
        n_gnt = 0; n_en = 0; n_rv = 0;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 4'hF;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ld_gnt0 || ld_gnt1) n_gnt++;
            if (mem_en0 || mem_en1) n_en++;
            if (ld_rvalid0 || ld_rvalid1 || ld_rdata0 != 8'h00 || ld_rdata1 != 8'h00) n_rv++;
        end
        ld_req = 1'b0;
        n_tests++;
        if (n_gnt !== 0 || n_en !== 0) begin
            n_fail++;
            $display("FAIL ld_read_disabled: gnt=%0d mem_en=%0d want 0 0", n_gnt, n_en);
        end
        n_tests++;
        if (n_rv !== 0) begin
            n_fail++;
            $display("FAIL ld_rdata_tied: active cycles=%0d want 0", n_rv);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_arbitration();
        test_prog_mode();
        test_readback();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
